// File: rtl/castlab_of_collector.sv
// Output-feature collector: de-skews per-column psums into aligned rows.
// Tracks frame completion, overflow drops and timed-out short frames.
module castlab_of_collector #(
    parameter int OF_NUM      = 4,
    parameter int OF_BITWIDTH = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int NUM_ROWS    = 64,
    parameter int TIMEOUT     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [OF_NUM*OF_BITWIDTH-1:0]     of_i_data,
    input  logic [OF_NUM-1:0]                 of_i_valid,
    input  logic                              of_i_done,
    output logic [OF_NUM*OF_BITWIDTH-1:0]     m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              m_last,
    output logic [$clog2(NUM_ROWS+1)-1:0]     m_row_cnt,
    output logic                              col_done,
    output logic                              ovf_err,
    output logic                              short_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(NUM_ROWS+1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int W  = OF_BITWIDTH;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WAIT,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [W-1:0]      mem    [OF_NUM][FIFO_DEPTH];
    logic [AW:0]       wr_ptr [OF_NUM];
    logic [AW:0]       rd_ptr [OF_NUM];
    logic [OF_NUM-1:0] empty;
    logic [OF_NUM-1:0] full;
    logic [OF_NUM-1:0] push_ok;
    logic [OF_NUM*W-1:0] head_row;
    logic              load;
    logic              hs;
    logic              flush;
    logic              drop;
    logic [TW-1:0]     tmo;
    logic [CW-1:0]     cnt_base;
    logic [CW-1:0]     row_idx;
    logic              last_nx;

    // FIFO status, head row, push acceptance and output-register load
    always_comb begin
        empty    = '0;
        full     = '0;
        push_ok  = '0;
        head_row = '0;
        for (int j = 0; j < OF_NUM; j++) begin
            empty[j] = (wr_ptr[j] == rd_ptr[j]);
            full[j]  = (wr_ptr[j][AW] != rd_ptr[j][AW]) &&
                       (wr_ptr[j][AW-1:0] == rd_ptr[j][AW-1:0]);
            head_row[j*W +: W] = mem[j][rd_ptr[j][AW-1:0]];
        end
        hs   = m_valid && m_ready;
        load = (&(~empty)) && (!m_valid || m_ready) && !flush;
        for (int j = 0; j < OF_NUM; j++) begin
            push_ok[j] = of_i_valid[j] && (!full[j] || load) && !flush;
        end
        drop     = (|(of_i_valid & full)) && !load && !flush;
        cnt_base = (state == DONE) ? '0 : m_row_cnt;
        row_idx  = cnt_base + CW'(m_valid);
        last_nx  = (row_idx == CW'(NUM_ROWS-1));
    end

    // Frame FSM: next state and timeout flush
    always_comb begin
        state_nx = state;
        flush    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|of_i_valid) state_nx = COLLECT;
            end
            COLLECT: begin
                if (hs && m_last)   state_nx = DONE;
                else if (of_i_done) state_nx = WAIT;
            end
            WAIT: begin
                if (hs && m_last) begin
                    state_nx = DONE;
                end else if (tmo == TW'(TIMEOUT-1)) begin
                    flush    = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign col_done = (state == DONE);

    // Lane FIFO storage writes
    always_ff @(posedge clk) begin
        for (int j = 0; j < OF_NUM; j++) begin
            if (push_ok[j]) mem[j][wr_ptr[j][AW-1:0]] <= of_i_data[j*W +: W];
        end
    end

    // Pointers, output register, counters, FSM state and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_row_cnt <= '0;
            ovf_err   <= 1'b0;
            short_err <= 1'b0;
            tmo       <= '0;
            for (int j = 0; j < OF_NUM; j++) begin
                wr_ptr[j] <= '0;
                rd_ptr[j] <= '0;
            end
        end else begin
            state <= state_nx;
            for (int j = 0; j < OF_NUM; j++) begin
                if (flush) begin
                    wr_ptr[j] <= '0;
                    rd_ptr[j] <= '0;
                end else begin
                    if (push_ok[j]) wr_ptr[j] <= wr_ptr[j] + PTR_ONE;
                    if (load)       rd_ptr[j] <= rd_ptr[j] + PTR_ONE;
                end
            end
            if (flush) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end else if (load) begin
                m_valid <= 1'b1;
                m_data  <= head_row;
                m_last  <= last_nx;
            end else if (hs) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            if (state == DONE) m_row_cnt <= hs ? CW'(1) : '0;
            else if (hs)       m_row_cnt <= m_row_cnt + CW'(1);
            if (state != WAIT) tmo <= '0;
            else               tmo <= tmo + TW'(1);
            if (drop)  ovf_err   <= 1'b1;
            if (flush) short_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_castlab_of_collector.sv
// Directed bench for castlab_of_collector: vector table for a
// normal frame plus sequences for stall, overflow, timeout, reset.
module tb_castlab_of_collector;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*W-1:0] of_i_data;
    logic [N-1:0]  of_i_valid;
    logic          of_i_done;
    logic [N*W-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [1:0]    m_row_cnt;
    logic          col_done;
    logic          ovf_err;
    logic          short_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cd_cnt  = 0;
    logic [64:0] got_q[$];

    castlab_of_collector #(
        .OF_NUM(N), .OF_BITWIDTH(W), .FIFO_DEPTH(8),
        .NUM_ROWS(3), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .of_i_data(of_i_data), .of_i_valid(of_i_valid),
        .of_i_done(of_i_done),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .m_row_cnt(m_row_cnt),
        .col_done(col_done), .ovf_err(ovf_err),
        .short_err(short_err)
    );

    always #5 clk = ~clk;

    // Handshake / frame-end monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) got_q.push_back({m_last, m_data});
        if (!rst && col_done) cd_cnt++;
    end

    typedef struct packed {
        logic [3:0]  vld;
        logic [63:0] din;
        logic        ev;
        logic        el;
        logic [1:0]  ec;
        logic        ecd;
        logic [63:0] ed;
    } vec_t;

    vec_t tv [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] row(input int r);
        logic [63:0] v;
        for (int j = 0; j < N; j++) v[j*W +: W] = 16'(j*16 + r);
        return v;
    endfunction

    function automatic logic [64:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return '0;
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        of_i_valid = '0;
        of_i_data = '0;
        of_i_done = 1'b0;
        step();
        step();
        rst = 1'b0;
        got_q.delete();
        cd_cnt = 0;
    endtask

    // Lane j presents row first+i in cycle i+j; lm masks lanes of the last row
    task automatic drive_skew(input int first, input int n,
                              input logic [3:0] lm);
        logic [3:0]  v;
        logic [63:0] d;
        int          i;
        for (int k = 0; k < n + 3; k++) begin
            v = '0;
            d = '0;
            for (int j = 0; j < N; j++) begin
                i = k - j;
                if (i >= 0 && i < n && (i < n - 1 || lm[j])) begin
                    v[j] = 1'b1;
                    d[j*W +: W] = 16'(j*16 + first + i);
                end
            end
            of_i_valid = v;
            of_i_data  = d;
            step();
        end
        of_i_valid = '0;
        of_i_data  = '0;
    endtask

    task automatic wait_rows(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) step();
        chk("row_count", 128'(got_q.size()), 128'(n));
    endtask

    initial begin
        tv[0] = '{4'b0001, 64'h0000_0000_0000_0001,
                  1'b0, 1'b0, 2'd0, 1'b0, 64'h0};
        tv[1] = '{4'b0011, 64'h0000_0000_0011_0002,
                  1'b0, 1'b0, 2'd0, 1'b0, 64'h0};
        tv[2] = '{4'b0111, 64'h0000_0021_0012_0003,
                  1'b0, 1'b0, 2'd0, 1'b0, 64'h0};
        tv[3] = '{4'b1110, 64'h0031_0022_0013_0000,
                  1'b0, 1'b0, 2'd0, 1'b0, 64'h0};
        tv[4] = '{4'b1100, 64'h0032_0023_0000_0000,
                  1'b1, 1'b0, 2'd0, 1'b0, 64'h0031_0021_0011_0001};
        tv[5] = '{4'b1000, 64'h0033_0000_0000_0000,
                  1'b1, 1'b0, 2'd1, 1'b0, 64'h0032_0022_0012_0002};
        tv[6] = '{4'b0000, 64'h0,
                  1'b1, 1'b1, 2'd2, 1'b0, 64'h0033_0023_0013_0003};
        tv[7] = '{4'b0000, 64'h0,
                  1'b0, 1'b0, 2'd3, 1'b1, 64'h0033_0023_0013_0003};
        tv[8] = '{4'b0000, 64'h0,
                  1'b0, 1'b0, 2'd0, 1'b0, 64'h0033_0023_0013_0003};

        // Reset state
        m_ready = 1'b1;
        reset_dut();
        chk("reset_outs",
            128'({m_data, m_valid, m_last, m_row_cnt,
                  col_done, ovf_err, short_err}), 128'(0));

        // Normal frame from the vector table
        for (int k = 0; k < 9; k++) begin
            of_i_valid = tv[k].vld;
            of_i_data  = tv[k].din;
            step();
            chk($sformatf("vec%0d", k),
                128'({m_valid, m_last, m_row_cnt, col_done, m_data}),
                128'({tv[k].ev, tv[k].el, tv[k].ec, tv[k].ecd, tv[k].ed}));
        end
        of_i_valid = '0;
        of_i_data  = '0;
        chk("norm_ovf", 128'(ovf_err), 128'(0));

        // Backpressure: six rows held behind m_ready=0
        m_ready = 1'b0;
        reset_dut();
        drive_skew(1, 6, 4'hF);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", 128'({m_valid, m_data}), 128'({1'b1, row(1)}));
            step();
        end
        m_ready = 1'b1;
        wait_rows(6, 30);
        for (int i = 0; i < 6; i++)
            chk("bp_row", 128'(got_at(i)) & 128'({64{1'b1}}),
                128'(row(i + 1)));
        chk("bp_ovf", 128'(ovf_err), 128'(0));

        // Overflow: 9 rows fit (8 FIFO + register), 10th is dropped
        m_ready = 1'b0;
        reset_dut();
        drive_skew(1, 9, 4'hF);
        chk("ovf_before", 128'(ovf_err), 128'(0));
        of_i_valid = 4'hF;
        of_i_data  = row(10);
        step();
        of_i_valid = '0;
        chk("ovf_after", 128'(ovf_err), 128'(1));
        m_ready = 1'b1;
        wait_rows(9, 40);
        repeat (5) step();
        chk("ovf_nrows", 128'(got_q.size()), 128'(9));
        for (int i = 0; i < 9; i++)
            chk("ovf_row", 128'(got_at(i)) & 128'({64{1'b1}}),
                128'(row(i + 1)));

        // Full FIFOs with simultaneous pop: no drop
        m_ready = 1'b1;
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            of_i_valid = 4'b0111;
            of_i_data  = row(k + 1) & 64'h0000_FFFF_FFFF_FFFF;
            step();
        end
        of_i_valid = 4'b1000;
        of_i_data  = row(1) & 64'hFFFF_0000_0000_0000;
        step();
        of_i_valid = 4'b1111;
        of_i_data  = (row(9) & 64'h0000_FFFF_FFFF_FFFF) |
                     (row(2) & 64'hFFFF_0000_0000_0000);
        step();
        chk("full_pop_ovf", 128'(ovf_err), 128'(0));
        for (int k = 3; k <= 9; k++) begin
            of_i_valid = 4'b1000;
            of_i_data  = row(k) & 64'hFFFF_0000_0000_0000;
            step();
        end
        of_i_valid = '0;
        wait_rows(9, 30);
        for (int i = 0; i < 9; i++)
            chk("full_row", 128'(got_at(i)) & 128'({64{1'b1}}),
                128'(row(i + 1)));
        chk("full_ovf_end", 128'(ovf_err), 128'(0));

        // Short frame: two rows plus a stray lane-0 word, then timeout
        m_ready = 1'b1;
        reset_dut();
        drive_skew(1, 3, 4'b0001);
        step();
        of_i_done = 1'b1;
        step();
        of_i_done = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            step();
            chk($sformatf("tmo_c%0d", i),
                128'({col_done, short_err}),
                128'({i == TO, i == TO}));
        end
        chk("tmo_mvalid", 128'(m_valid), 128'(0));
        chk("tmo_nrows", 128'(got_q.size()), 128'(2));
        step();
        chk("tmo_sticky", 128'(short_err), 128'(1));
        got_q.delete();
        drive_skew(4, 3, 4'hF);
        wait_rows(3, 20);
        for (int i = 0; i < 3; i++)
            chk("post_tmo_row", 128'(got_at(i)),
                128'({i == 2, row(4 + i)}));

        // Reset while a row is held and a partial row is queued
        m_ready = 1'b0;
        reset_dut();
        drive_skew(1, 3, 4'b0011);
        chk("pre_rst_valid", 128'({m_valid, m_data}),
            128'({1'b1, row(1)}));
        rst = 1'b1;
        step();
        chk("mid_rst_outs",
            128'({m_data, m_valid, m_last, m_row_cnt,
                  col_done, ovf_err, short_err}), 128'(0));
        rst = 1'b0;
        got_q.delete();
        cd_cnt = 0;
        m_ready = 1'b1;
        drive_skew(1, 3, 4'hF);
        wait_rows(3, 20);
        for (int i = 0; i < 3; i++)
            chk("post_rst_row", 128'(got_at(i)),
                128'({i == 2, row(1 + i)}));
        repeat (3) step();
        chk("post_rst_done", 128'(cd_cnt), 128'(1));
        chk("post_rst_cnt", 128'(m_row_cnt), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired tests=%0d", n_tests);
        $fatal(1);
    end

endmodule
